// File: rtl/pulse_pkg.sv
// rtl/pulse_pkg.sv - shared constants and state type for the psi pulse-width link
package pulse_pkg;
    localparam int PULSE_WIDTH   = 8;
    localparam int PULSE_MIN_GAP = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;
endpackage

// File: rtl/pulse_tx_if.sv
// rtl/pulse_tx_if.sv - valid/ready word handshake into the pulse transmitter
interface pulse_tx_if
    import pulse_pkg::*;
#(
    parameter int WIDTH = PULSE_WIDTH
) ();
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;

    modport master (output in_valid, output in_data, input  in_ready);
    modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/pulse_tx_load_down_counter.sv
// rtl/pulse_tx_load_down_counter.sv - loadable down counter that saturates at zero
module load_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);
    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);
endmodule

// File: rtl/pulse_tx.sv
// rtl/pulse_tx.sv - sends each word D as D+1 high cycles on psi, then MIN_GAP low cycles
module pulse_tx
    import pulse_pkg::*;
#(
    parameter int WIDTH   = PULSE_WIDTH,
    parameter int MIN_GAP = PULSE_MIN_GAP
) (
    input  logic       clk,
    input  logic       rst,
    pulse_tx_if.slave  s_in,
    output logic       psi,
    output logic       busy,
    output logic       done
);
    state_t           r_state;
    state_t           w_next;
    logic             r_full;
    logic [WIDTH-1:0] r_hold;
    logic             r_psi;
    logic             w_xfer;
    logic             w_take;
    logic             w_hi_load;
    logic             w_hi_dec;
    logic             w_hi_zero;
    logic             w_gap_load;
    logic             w_gap_dec;
    logic             w_gap_zero;

    assign s_in.in_ready = !r_full;
    assign w_xfer        = s_in.in_valid && !r_full;

    // A write and a load on the same edge both take effect; the write wins the full flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_hold <= '0;
        end else begin
            if (w_take) begin
                r_full <= 1'b0;
            end
            if (w_xfer) begin
                r_full <= 1'b1;
                r_hold <= s_in.in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_psi   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_psi   <= (w_next == HIGH);
        end
    end

    always_comb begin
        w_next     = r_state;
        w_take     = 1'b0;
        w_hi_load  = 1'b0;
        w_hi_dec   = 1'b0;
        w_gap_load = 1'b0;
        w_gap_dec  = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_full) begin
                    w_hi_load = 1'b1;
                    w_take    = 1'b1;
                    w_next    = HIGH;
                end
            end
            HIGH: begin
                if (w_hi_zero) begin
                    w_gap_load = 1'b1;
                    w_next     = GAP;
                end else begin
                    w_hi_dec = 1'b1;
                end
            end
            GAP: begin
                if (!w_gap_zero) begin
                    w_gap_dec = 1'b1;
                end else if (r_full) begin
                    w_hi_load = 1'b1;
                    w_take    = 1'b1;
                    w_next    = HIGH;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    load_down_counter #(.W(WIDTH)) u_hi_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_hi_load),
        .i_load_val (r_hold),
        .i_dec      (w_hi_dec),
        .o_zero     (w_hi_zero)
    );

    load_down_counter #(.W(8)) u_gap_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_gap_load),
        .i_load_val (8'(MIN_GAP - 1)),
        .i_dec      (w_gap_dec),
        .o_zero     (w_gap_zero)
    );

    assign psi  = r_psi;
    assign busy = (r_state != IDLE);
    assign done = (r_state == GAP) && w_gap_zero;
endmodule

// File: tb/tb_pulse_tx.sv
// tb/tb_pulse_tx.sv - randomized and directed bench for pulse_tx against a timeline model
module tb_pulse_tx;
    import pulse_pkg::*;

    localparam int MAXC = 4096;
    localparam int MG   = PULSE_MIN_GAP;

    logic clk = 1'b0;
    logic rst;
    logic psi, busy, done;

    pulse_tx_if #(.WIDTH(PULSE_WIDTH)) bus ();

    pulse_tx #(.WIDTH(PULSE_WIDTH), .MIN_GAP(MG)) dut (
        .clk  (clk),
        .rst  (rst),
        .s_in (bus),
        .psi  (psi),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc;
    int next_free;
    bit e_psi  [MAXC];
    bit e_busy [MAXC];
    bit e_done [MAXC];
    bit e_full [MAXC];
    int sent_q[$];
    int rx_q[$];
    bit rx_prev;
    int rx_cnt;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    // Expected waveform of one accepted word, placed on the absolute cycle timeline.
    task automatic schedule(int t, int d);
        int start;
        start = (t + 1 > next_free) ? t + 1 : next_free;
        for (int c = t; c < start; c++) if (c < MAXC) e_full[c] = 1'b1;
        for (int c = start; c <= start + d + MG; c++) begin
            if (c < MAXC) begin
                e_busy[c] = 1'b1;
                if (c <= start + d) e_psi[c] = 1'b1;
            end
        end
        if (start + d + MG < MAXC) e_done[start + d + MG] = 1'b1;
        next_free = start + d + 1 + MG;
        sent_q.push_back(d);
    endtask

    task automatic tick(output bit acc);
        bit rdy;
        rdy = (cyc < 0) ? 1'b1 : !e_full[cyc];
        acc = bus.in_valid && rdy;
        @(posedge clk);
        cyc++;
        if (acc) schedule(cyc, int'(bus.in_data));
        @(negedge clk);
        chk("psi",      psi,          e_psi[cyc]);
        chk("busy",     busy,         e_busy[cyc]);
        chk("done",     done,         e_done[cyc]);
        chk("in_ready", bus.in_ready, !e_full[cyc]);
        // loopback receiver: restart on rising edge, count extra high cycles
        if (psi && !rx_prev) rx_cnt = 0;
        else if (psi) rx_cnt++;
        if (!psi && rx_prev) rx_q.push_back(rx_cnt);
        rx_prev = psi;
        if (acc) bus.in_valid = 1'b0;
    endtask

    task automatic idle(int n);
        bit acc;
        for (int i = 0; i < n; i++) tick(acc);
    endtask

    task automatic offer(int d);
        bit acc;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'(d);
        acc = 1'b0;
        for (int n = 0; n < 600 && !acc; n++) tick(acc);
        if (!acc) begin
            chk("offer_timeout", 0, 1);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = next_free - cyc + 2;
        if (n > 0) idle(n);
        chk("rx_count", rx_q.size(), sent_q.size());
        for (int i = 0; i < rx_q.size() && i < sent_q.size(); i++)
            chk("rx_word", rx_q[i], sent_q[i]);
        rx_q.delete();
        sent_q.delete();
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_psi",      psi,          0);
        chk("rst_busy",     busy,         0);
        chk("rst_done",     done,         0);
        chk("rst_in_ready", bus.in_ready, 1);
        rst = 1'b0;
        for (int c = 0; c < MAXC; c++) begin
            e_psi[c]  = 1'b0;
            e_busy[c] = 1'b0;
            e_done[c] = 1'b0;
            e_full[c] = 1'b0;
        end
        cyc       = -1;
        next_free = 0;
        sent_q.delete();
        rx_q.delete();
        rx_prev = 1'b0;
        rx_cnt  = 0;
    endtask

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        cyc          = -1;
        next_free    = 0;
        do_reset();

        offer(0);
        drain();
        offer(5);
        drain();
        offer(3);
        offer(1);
        offer(2);
        drain();
        offer(255);
        drain();

        for (int k = 0; k < 40; k++) begin
            offer(int'($urandom_range(0, 40)));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(0, 6)));
        end
        drain();

        do_reset();
        offer(10);
        offer(7);
        idle(1);
        do_reset();
        idle(40);
        chk("rst_no_tx", rx_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pulse_tx.md
# pulse_tx

Pulse-width transmitter: accepts an 8-bit duration word over a valid/ready handshake and drives it onto the single-wire `psi` line as a high pulse followed by a guaranteed low gap. It is the transmit end of the `psi` pulse-width link. The receive end restarts its count on the rising edge of `psi` and increments once per additional high cycle, so a word D is sent as exactly D+1 high cycles. `pulse_tx` sits between a word source (test sequencer, register, or FIFO) and the `psi` wire.

## Interface
- `WIDTH`, 8: duration word width.
- `MIN_GAP`, 2: number of low cycles forced after every pulse; legal range 1..255.
- `clk`  in  1: rising-edge clock; the only clock.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: source offers `in_data`.
- `in_data`  in  WIDTH: duration D to transmit.
- `in_ready`  out  1: one-entry holding register is empty.
- `psi`  out  1: registered pulse output.
- `busy`  out  1: the FSM is in HIGH or GAP.
- `done`  out  1: one-cycle strobe on the last GAP cycle of each pulse.

## Operation
- Reset values at the first edge with `rst`=1:
  - `psi`=0, `busy`=0, `done`=0, `in_ready`=1.
  - Holding register empty, FSM in IDLE, both counters 0.
- Handshake:
  - A transfer occurs on an edge where `in_valid`&&`in_ready`; the word is written into the holding register.
  - `in_ready` = holding register empty.
  - While the register is full, the source must hold `in_valid` and `in_data` stable. No word is ever dropped or overwritten.
- FSM states:
  - IDLE: `psi`=0. If the holding register is full, load the high counter with D, clear the register, and go to HIGH.
  - HIGH: `psi`=1. If the counter is 0, load the gap counter with MIN_GAP-1 and go to GAP; otherwise decrement.
  - GAP: `psi`=0. If the gap counter is nonzero, decrement.
    - At 0 with the register full: load the next word, clear the register, and go straight to HIGH. There is no IDLE cycle.
    - At 0 with the register empty: go to IDLE.
- Arithmetic rules:
  - High counter is WIDTH bits and counts down only, so D=255 gives 256 high cycles with no wrap.
  - Gap counter is 8 bits.
- `done` = 1 exactly during the final GAP cycle.
- Boundary conditions:
  - A transfer on the same edge that the FSM empties the register is legal: the load and the write both happen, and the new word is held.
  - Reset mid-pulse: `psi` drops at the next edge with `rst`=1. Any held word is discarded.
  - D=0 produces a single high cycle.

## Timing
- Cycle n is the interval after edge n. A transfer occurs at edge 0 with an idle FSM.
- Cycle 0: register full, `in_ready`=0, `psi`=0.
- Cycles 1..D+1: `psi`=1, `busy`=1, `in_ready`=1.
- Cycles D+2..D+1+MIN_GAP: `psi`=0, `busy`=1; `done`=1 in cycle D+1+MIN_GAP.
- Cycle D+2+MIN_GAP:
  - Next pulse high if a word is held.
  - Otherwise IDLE, `busy`=0.
- Latency from transfer edge to first high cycle: 1 cycle.
- Steady-state period: D+1+MIN_GAP cycles per word.

## Structure
- Shared package `pulse_pkg`:
  - State enum {IDLE, HIGH, GAP}.
  - `PULSE_WIDTH`=8.
  - `PULSE_MIN_GAP`=2.
  - These constants are shared with the receive side.
- One sub-module, `load_down_counter`:
  - Parameterised width; inputs load, load value, decrement enable; output zero flag.
  - Instantiated twice, once for HIGH and once for GAP.

## Test plan
- Reset, then D=0 transferred at edge 0 → `psi`=1 in cycle 1 only, low in cycles 2–3, `done` in cycle 3, `busy`=0 in cycle 4.
- D=5 → `psi` high in cycles 1..6, low in cycles 7–8, `done` in cycle 8; a loopback receive block reports 5.
- Back-to-back D=3, then D=1 offered in cycle 1 → high 1..4, low 5..6, high 7..8; no IDLE cycle between the pulses.
- Third word offered while the register is full → `in_ready`=0 until the register empties, then accepted; all three words appear on `psi` in order.
- D=255 → exactly 256 consecutive high cycles; loopback receive block reports 255.
- `rst` asserted in the 3rd high cycle of D=10 with a word held → `psi`=0 in the next cycle, `in_ready`=1, `busy`=0, no `done`, held word never transmitted.
